pipe_scroller: RTL and testbench

//  Pipe-field generator/scroller for the LED-matrix game; sits directly downstream of the slow tick counter.

---
 rtl/pipe_scroller_if.sv | 14 +
 rtl/pipe_scroller.sv | 74 +++++++
 tb/tb_pipe_scroller.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_scroller_if.sv
// pipe_scroller_if: control inputs and grid/pulse outputs of the pipe scroller.
interface pipe_scroller_if #(
   parameter int ROWS = 16,
   parameter int COLS = 16
);
   logic tick;
   logic run;
   logic clear;
   logic [ROWS*COLS-1:0] grid;
   logic step;
   logic score_pulse;
   modport master(output tick, run, clear, input grid, step, score_pulse);
   modport slave(input tick, run, clear, output grid, step, score_pulse);
endinterface

// File: rtl/pipe_scroller.sv
// pipe_scroller: edge-stepped pipe-field scroller for the LED-matrix game.
// Define RANDOM_GAP_EN for LFSR-placed gaps; otherwise gaps walk by +3 rows per pipe.
module pipe_scroller #(
   parameter int ROWS = 16,
   parameter int COLS = 16,
   parameter int GAP = 4,
   parameter int SPACING = 6,
   parameter int BIRD_COL = 3,
   parameter logic [7:0] SEED = 8'hA5
) (
   input logic clk,
   input logic reset,
   pipe_scroller_if.slave bus
);
   localparam int NG = ROWS - GAP + 1;
   localparam int GW = $clog2(ROWS + 1);
   localparam int SW = $clog2(SPACING);
   typedef enum logic {IDLE, RUN} state_t;
   state_t state;
   logic tick_q;
   logic adv;
   logic pipe;
   logic emit;
   logic [SW-1:0] sp_cnt;
   logic [GW-1:0] gap_top;
   logic [ROWS-1:0] new_col;
   logic [ROWS-1:0] bird_col;
   assign adv = state == RUN && bus.tick && !tick_q;
   assign pipe = sp_cnt == SW'(SPACING - 1);
   assign emit = adv && pipe && !bus.clear;
   always_comb begin
      new_col = '0;
      bird_col = '0;
      for (int r = 0; r < ROWS; r++) begin
         new_col[r] = pipe && (r < int'(gap_top) || r >= int'(gap_top) + GAP);
         bird_col[r] = bus.grid[r*COLS+BIRD_COL];
      end
   end
`ifdef RANDOM_GAP_EN
   logic [7:0] lfsr;
   assign gap_top = GW'(int'(lfsr) % NG);
   always_ff @(posedge clk)
      if (reset) lfsr <= SEED;
      else if (emit) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
`else
   always_ff @(posedge clk)
      if (reset) gap_top <= GW'(6 % NG);
      else if (emit) gap_top <= GW'((int'(gap_top) + 3) % NG);
`endif
   // clear drops a coincident advance but leaves the gap source running on
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         tick_q <= 1'b0;
         sp_cnt <= '0;
         bus.grid <= '0;
         bus.step <= 1'b0;
         bus.score_pulse <= 1'b0;
      end else begin
         state <= bus.run ? RUN : IDLE;
         tick_q <= bus.tick;
         bus.step <= adv && !bus.clear;
         bus.score_pulse <= adv && !bus.clear && |bird_col;
         if (bus.clear) begin
            bus.grid <= '0;
            sp_cnt <= '0;
         end else if (adv) begin
            sp_cnt <= pipe ? '0 : sp_cnt + SW'(1);
            for (int r = 0; r < ROWS; r++)
               bus.grid[r*COLS +: COLS] <= {new_col[r], bus.grid[r*COLS+1 +: COLS-1]};
         end
      end
   end
endmodule

// File: tb/tb_pipe_scroller.sv
// tb_pipe_scroller: vector table, corner sequences and random run against a column-level model.
module tb_pipe_scroller;
   localparam int ROWS = 16, COLS = 16, GAP = 4, SPACING = 6, BIRD_COL = 3;
   localparam int NG = ROWS - GAP + 1;
   localparam logic [7:0] SEED = 8'hA5;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;
   pipe_scroller_if #(.ROWS(ROWS), .COLS(COLS)) bus();
   pipe_scroller dut(.clk(clk), .reset(reset), .bus(bus));
   int checks = 0, errors = 0;
   int n_step = 0, n_score = 0;
   logic [ROWS-1:0] mc [COLS];
   logic m_run, m_tq, m_step, m_score;
   int m_nsc, m_pipes;
   logic [ROWS-1:0] p0, p1;
   typedef struct {
      logic t;
      logic r;
      logic c;
      logic st;
      logic [ROWS-1:0] col15;
   } vec_t;
   vec_t tbl[18];
   function automatic int gap_of(input int k);
`ifdef RANDOM_GAP_EN
      logic [7:0] l;
      l = SEED;
      repeat (k) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
      return int'(l) % NG;
`else
      return (6 + 3 * k) % NG;
`endif
   endfunction
   function automatic logic [ROWS-1:0] pipe_col(input int g);
      logic [ROWS-1:0] v;
      for (int r = 0; r < ROWS; r++) v[r] = (r < g || r >= g + GAP);
      return v;
   endfunction
   function automatic logic [ROWS-1:0] col_of(input logic [ROWS*COLS-1:0] g, input int c);
      logic [ROWS-1:0] v;
      for (int r = 0; r < ROWS; r++) v[r] = g[r*COLS+c];
      return v;
   endfunction
   function automatic logic [ROWS*COLS-1:0] exp_grid();
      logic [ROWS*COLS-1:0] g;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) g[r*COLS+c] = mc[c][r];
      return g;
   endfunction
   task automatic check(input string nm, input logic [ROWS*COLS-1:0] act, input logic [ROWS*COLS-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask
   // columns kept as a list; a pipe enters every SPACING-th advance since clear/reset
   task automatic model(input logic t, input logic r, input logic c, input logic rs);
      logic adv;
      if (rs) begin
         foreach (mc[i]) mc[i] = '0;
         m_run = 0; m_tq = 0; m_step = 0; m_score = 0; m_nsc = 0; m_pipes = 0;
      end else begin
         adv = m_run && t && !m_tq;
         m_step = adv && !c;
         m_score = adv && !c && mc[BIRD_COL] != '0;
         if (c) begin
            foreach (mc[i]) mc[i] = '0;
            m_nsc = 0;
         end else if (adv) begin
            for (int i = 0; i < COLS - 1; i++) mc[i] = mc[i+1];
            m_nsc++;
            if (m_nsc % SPACING == 0) begin
               mc[COLS-1] = pipe_col(gap_of(m_pipes));
               m_pipes++;
            end else mc[COLS-1] = '0;
         end
         m_tq = t;
         m_run = r;
      end
   endtask
   task automatic cycle(input logic t, input logic r, input logic c, input logic rs);
      bus.tick = t; bus.run = r; bus.clear = c; reset = rs;
      model(t, r, c, rs);
      @(posedge clk);
      #1;
      check("grid", bus.grid, exp_grid());
      check("step", bus.step, m_step);
      check("score", bus.score_pulse, m_score);
      n_step += int'(bus.step);
      n_score += int'(bus.score_pulse);
   endtask
   initial begin
      int s0;
      logic [ROWS*COLS-1:0] g0;
      logic [ROWS-1:0] v;
      int z;
`ifdef RANDOM_GAP_EN
      p0 = pipe_col(gap_of(0));
      p1 = pipe_col(gap_of(1));
`else
      p0 = 16'hFC3F;
      p1 = 16'hE1FF;
`endif
      tbl[0] = '{t: 0, r: 1, c: 0, st: 0, col15: '0};
      for (int i = 1; i <= 10; i++) tbl[i] = '{t: i[0], r: 1, c: 0, st: i[0], col15: '0};
      tbl[11] = '{t: 1, r: 1, c: 0, st: 1, col15: p0};
      tbl[12] = '{t: 1, r: 1, c: 0, st: 0, col15: p0};
      tbl[13] = '{t: 0, r: 1, c: 0, st: 0, col15: p0};
      tbl[14] = '{t: 1, r: 1, c: 0, st: 1, col15: '0};
      tbl[15] = '{t: 0, r: 1, c: 0, st: 0, col15: '0};
      tbl[16] = '{t: 1, r: 1, c: 1, st: 0, col15: '0};
      tbl[17] = '{t: 0, r: 1, c: 0, st: 0, col15: '0};
      cycle(0, 0, 0, 1);
      cycle(0, 0, 0, 1);
      check("rst_grid", bus.grid, '0);
      check("rst_step", bus.step, 1'b0);
      check("rst_score", bus.score_pulse, 1'b0);
      for (int i = 0; i < 18; i++) begin
         cycle(tbl[i].t, tbl[i].r, tbl[i].c, 0);
         check("tbl_step", bus.step, tbl[i].st);
         check("tbl_col15", col_of(bus.grid, COLS - 1), tbl[i].col15);
         if (tbl[i].c) check("clr_grid", bus.grid, '0);
      end
      for (int e = 1; e <= 6; e++) begin
         cycle(1, 1, 0, 0);
         check("clr_next_pipe", col_of(bus.grid, COLS - 1), e == 6 ? p1 : '0);
         cycle(0, 1, 0, 0);
      end
      s0 = n_step;
      repeat (50) cycle(1, 1, 0, 0);
      check("hold_steps", n_step - s0, 1);
      cycle(0, 1, 0, 0);
      cycle(0, 1, 0, 1);
      cycle(0, 1, 0, 1);
      cycle(0, 1, 0, 0);
      s0 = n_score;
      for (int e = 1; e <= 19; e++) begin
         cycle(1, 1, 0, 0);
         if (e == 6) check("rst_restart_gap", col_of(bus.grid, COLS - 1), p0);
         if (e == 12) check("second_gap", col_of(bus.grid, COLS - 1), p1);
         if (e == 18) check("bird_col18", col_of(bus.grid, BIRD_COL), p0);
         if (e == 19) begin
            check("score19", bus.score_pulse, 1'b1);
            check("col2_19", col_of(bus.grid, BIRD_COL - 1), p0);
         end
         cycle(0, 1, 0, 0);
      end
      check("score_cnt", n_score - s0, 1);
      g0 = bus.grid;
      s0 = n_step;
      cycle(0, 0, 0, 0);
      repeat (10) begin
         cycle(1, 0, 0, 0);
         cycle(0, 0, 0, 0);
      end
      check("idle_steps", n_step - s0, 0);
      check("idle_grid", bus.grid, g0);
      cycle(0, 1, 0, 0);
      cycle(1, 1, 0, 0);
      check("resume_step", bus.step, 1'b1);
      cycle(0, 1, 0, 0);
      cycle(1, 0, 0, 0);
      check("run_fall_step", bus.step, 1'b1);
      cycle(0, 1, 0, 0);
      for (int i = 0; i < 8000; i++) begin
         cycle(1'($urandom_range(0, 1)), $urandom_range(0, 19) != 0,
               $urandom_range(0, 199) == 0, $urandom_range(0, 1999) == 0);
         v = col_of(bus.grid, COLS - 1);
         if (bus.step && v != '0) begin
            z = 0;
            for (int r = 0; r < ROWS; r++) z += int'(!v[r]);
            check("gap_rows", z, GAP);
         end
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
